// File: rtl/messbauer_velocity_reference_generator.sv
// Velocity reference generator for the Moessbauer drive DAC.
// Produces a sawtooth or symmetric triangle staircase of 2^CHANNEL_BITS
// steps per slope, each step held CHANNEL_CLOCKS cycles. A spectrum channel
// index, a channel-change strobe, a period-start pulse and a slope flag are
// provided alongside, so the counting side can address spectrum channels.
//
// Control semantics (no valid/ready handshake on this block):
//   enable       - level; sampled at every period boundary and in IDLE.
//   mode         - level; latched only when a period starts.
//   sync_restart - level; any edge with it high while running restarts
//                  the period at channel 0.
// All outputs are registered; channel, out_value and channel_strobe change
// on the same edge. dbg_state exposes the FSM state for checkers.
module messbauer_velocity_reference_generator #(
  parameter int OUT_WIDTH      = 12,
  parameter int CHANNEL_BITS   = 9,
  parameter int CHANNEL_CLOCKS = 16
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    sync_restart,
  output logic [OUT_WIDTH-1:0]    out_value,
  output logic [CHANNEL_BITS:0]   channel,
  output logic                    channel_strobe,
  output logic                    period_start,
  output logic                    slope_up,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int SHIFT = OUT_WIDTH - CHANNEL_BITS;
  localparam int DW    = (CHANNEL_CLOCKS > 1) ? $clog2(CHANNEL_CLOCKS) : 1;
  localparam logic [DW-1:0]         DWELL_LAST = DW'(CHANNEL_CLOCKS - 1);
  // Last channel of the rising slope (N-1) and of the falling slope (2N-1).
  localparam logic [CHANNEL_BITS:0] CH_UP_LAST = (CHANNEL_BITS+1)'((2 ** CHANNEL_BITS) - 1);
  localparam logic [CHANNEL_BITS:0] CH_DN_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_dwell;
  logic [CHANNEL_BITS:0]   r_channel;
  logic [OUT_WIDTH-1:0]    r_out;
  logic                    r_strobe;
  logic                    r_period_start;
  logic                    r_slope_up;
  logic                    r_mode;

  logic [CHANNEL_BITS:0]   w_ch_next;
  logic [CHANNEL_BITS-1:0] w_code_up;
  logic [CHANNEL_BITS-1:0] w_code_dn;
  logic [OUT_WIDTH-1:0]    w_out_up;
  logic [OUT_WIDTH-1:0]    w_out_dn;
  logic                    w_running;
  logic                    w_dwell_done;
  logic                    w_period_end;
  logic                    w_boundary;
  logic                    w_start;
  logic                    w_stop;

  // DAC code of the next channel. On the falling slope channel c maps to
  // 2N-1-c, which is the bitwise inverse of the low CHANNEL_BITS of c.
  assign w_ch_next = r_channel + 1'b1;
  assign w_code_up = w_ch_next[CHANNEL_BITS-1:0];
  assign w_code_dn = ~w_ch_next[CHANNEL_BITS-1:0];
  assign w_out_up  = OUT_WIDTH'(w_code_up) << SHIFT;
  assign w_out_dn  = OUT_WIDTH'(w_code_dn) << SHIFT;

  // Period boundary decode: a sawtooth ends at the top of RUN_UP, a triangle
  // at the bottom of RUN_DOWN. sync_restart overrides everything while running.
  assign w_running    = (r_state != ST_IDLE);
  assign w_dwell_done = (r_dwell == DWELL_LAST);
  assign w_period_end = ((r_state == ST_RUN_UP)   && (r_channel == CH_UP_LAST) && !r_mode) ||
                        ((r_state == ST_RUN_DOWN) && (r_channel == CH_DN_LAST));
  assign w_boundary   = w_running && !sync_restart && w_dwell_done && w_period_end;
  assign w_start      = (!w_running && enable) ||
                        (w_running && sync_restart) ||
                        (w_boundary && enable);
  assign w_stop       = w_boundary && !enable;

  // Main FSM: period start/stop, dwell counting and channel stepping.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state        <= ST_IDLE;
      r_dwell        <= '0;
      r_channel      <= '0;
      r_out          <= '0;
      r_strobe       <= 1'b0;
      r_period_start <= 1'b0;
      r_slope_up     <= 1'b0;
      r_mode         <= 1'b0;
    end else begin
      r_strobe       <= 1'b0;
      r_period_start <= 1'b0;
      if (w_start) begin
        r_state        <= ST_RUN_UP;
        r_dwell        <= '0;
        r_channel      <= '0;
        r_out          <= '0;
        r_strobe       <= 1'b1;
        r_period_start <= 1'b1;
        r_slope_up     <= 1'b1;
        r_mode         <= mode;
      end else if (w_stop) begin
        r_state    <= ST_IDLE;
        r_dwell    <= '0;
        r_channel  <= '0;
        r_out      <= '0;
        r_slope_up <= 1'b0;
      end else if (w_running) begin
        if (!w_dwell_done) begin
          r_dwell <= r_dwell + 1'b1;
        end else begin
          r_dwell   <= '0;
          r_channel <= w_ch_next;
          r_strobe  <= 1'b1;
          if ((r_state == ST_RUN_UP) && (r_channel != CH_UP_LAST)) begin
            r_out <= w_out_up;
          end else begin
            // Falling slope, or the triangle turn-around from channel N-1 to N.
            r_out <= w_out_dn;
            if (r_state == ST_RUN_UP) begin
              r_state    <= ST_RUN_DOWN;
              r_slope_up <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign out_value      = r_out;
  assign channel        = r_channel;
  assign channel_strobe = r_strobe;
  assign period_start   = r_period_start;
  assign slope_up       = r_slope_up;
  assign busy           = w_running;
  assign dbg_state      = r_state;

endmodule
